// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster types and 1280x720@60 timing constants
package video_timing_pkg;

  localparam int POS_W = 12;
  typedef logic signed [POS_W-1:0] pos_t;

  localparam int HRES  = 1280;
  localparam int HFP   = 110;
  localparam int HSYNC = 40;
  localparam int HBP   = 220;
  localparam int VRES  = 720;
  localparam int VFP   = 5;
  localparam int VSYNC = 5;
  localparam int VBP   = 20;

  localparam int H_TOTAL = HRES + HFP + HSYNC + HBP;
  localparam int V_TOTAL = VRES + VFP + VSYNC + VBP;

  localparam logic HS_POL = 1'b1;
  localparam logic VS_POL = 1'b1;

  // Blanking is negative so the first active coordinate is 0.
  function automatic int blank_start(input int fp, input int sync, input int bp);
    return -(fp + sync + bp);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - shared video raster interface (position, flags, syncs)
interface video_timing_gen_if;
  import video_timing_pkg::*;

  pos_t        hpos;
  pos_t        vpos;
  logic        active;
  logic        hsync;
  logic        vsync;
  logic        fsync;
  logic        lsync;
  logic [15:0] frame_cnt;

  modport master (
    output hpos, vpos, active, hsync, vsync, fsync, lsync, frame_cnt
  );

  modport slave (
    input hpos, vpos, active, hsync, vsync, fsync, lsync, frame_cnt
  );

endinterface

// File: rtl/vtg_axis_counter.sv
// rtl/vtg_axis_counter.sv - one signed wrapping raster axis counter with next-value decode
module vtg_axis_counter
  import video_timing_pkg::*;
#(
  parameter pos_t START   = '0,
  parameter pos_t END     = '0,
  parameter pos_t SYNC_LO = '0,
  parameter pos_t SYNC_HI = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output pos_t pos_o,
  output logic wrap_o,
  output logic act_nxt_o,
  output logic sync_nxt_o
);

  pos_t cnt_q;
  pos_t cnt_d;
  logic wrap;

  // Next count plus decodes of that next value, so the owner can register
  // flags that line up with the position they describe.
  always_comb begin
    wrap       = en_i && (cnt_q == END);
    cnt_d      = cnt_q;
    if (en_i) begin
      cnt_d = wrap ? START : cnt_q + pos_t'(1);
    end
    act_nxt_o  = ~cnt_d[$bits(pos_t)-1];
    sync_nxt_o = (cnt_d >= SYNC_LO) && (cnt_d < SYNC_HI);
  end

  // Resting at END means the first enabled edge after reset lands on START.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= END;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pos_o  = cnt_q;
  assign wrap_o = wrap;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator; VTG_FRAME_CNT_EN enables frame_cnt
module video_timing_gen #(
  parameter int   HRES   = video_timing_pkg::HRES,
  parameter int   HFP    = video_timing_pkg::HFP,
  parameter int   HSYNC  = video_timing_pkg::HSYNC,
  parameter int   HBP    = video_timing_pkg::HBP,
  parameter int   VRES   = video_timing_pkg::VRES,
  parameter int   VFP    = video_timing_pkg::VFP,
  parameter int   VSYNC  = video_timing_pkg::VSYNC,
  parameter int   VBP    = video_timing_pkg::VBP,
  parameter logic HS_POL = video_timing_pkg::HS_POL,
  parameter logic VS_POL = video_timing_pkg::VS_POL,
  parameter int   POS_W  = video_timing_pkg::POS_W
) (
  input  logic                      pixel_clk,
  input  logic                      rst,
  video_timing_gen_if.master        vid
);
  import video_timing_pkg::*;

  localparam int H_START = blank_start(HFP, HSYNC, HBP);
  localparam int V_START = blank_start(VFP, VSYNC, VBP);
  localparam int HS_LO   = H_START + HFP;
  localparam int HS_HI   = HS_LO + HSYNC;
  localparam int VS_LO   = V_START + VFP;
  localparam int VS_HI   = VS_LO + VSYNC;
  localparam int POS_MAX = 2 ** (POS_W - 1) - 1;
  localparam int POS_MIN = -(2 ** (POS_W - 1));

  if (POS_W != $bits(pos_t)) begin : g_chk_width
    $error("video_timing_gen: POS_W does not match pos_t width");
  end
  if (H_START < POS_MIN || V_START < POS_MIN) begin : g_chk_start
    $error("video_timing_gen: blanking start does not fit in POS_W");
  end
  if (HRES > POS_MAX || VRES > POS_MAX) begin : g_chk_res
    $error("video_timing_gen: active resolution does not fit in POS_W");
  end

  logic h_wrap, h_act_nxt, h_sync_nxt;
  logic v_wrap, v_act_nxt, v_sync_nxt;

  vtg_axis_counter #(
    .START   (pos_t'(H_START)),
    .END     (pos_t'(HRES - 1)),
    .SYNC_LO (pos_t'(HS_LO)),
    .SYNC_HI (pos_t'(HS_HI))
  ) u_hcnt (
    .clk_i      (pixel_clk),
    .rst_i      (rst),
    .en_i       (1'b1),
    .pos_o      (vid.hpos),
    .wrap_o     (h_wrap),
    .act_nxt_o  (h_act_nxt),
    .sync_nxt_o (h_sync_nxt)
  );

  vtg_axis_counter #(
    .START   (pos_t'(V_START)),
    .END     (pos_t'(VRES - 1)),
    .SYNC_LO (pos_t'(VS_LO)),
    .SYNC_HI (pos_t'(VS_HI))
  ) u_vcnt (
    .clk_i      (pixel_clk),
    .rst_i      (rst),
    .en_i       (h_wrap),
    .pos_o      (vid.vpos),
    .wrap_o     (v_wrap),
    .act_nxt_o  (v_act_nxt),
    .sync_nxt_o (v_sync_nxt)
  );

  logic active_q, hsync_q, vsync_q, fsync_q, lsync_q;
  logic active_d, hsync_d, vsync_d, fsync_d, lsync_d;

  // Flags for the pixel the counters are about to show. v_wrap already
  // implies h_wrap, so it alone marks the first pixel of the next frame.
  always_comb begin
    active_d = h_act_nxt & v_act_nxt;
    hsync_d  = h_sync_nxt ? HS_POL : ~HS_POL;
    vsync_d  = v_sync_nxt ? VS_POL : ~VS_POL;
    lsync_d  = h_wrap;
    fsync_d  = v_wrap;
  end

  // Flag registers, updated on the same edge as the counters.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      fsync_q  <= 1'b0;
      lsync_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fsync_q  <= fsync_d;
      lsync_q  <= lsync_d;
    end
  end

  assign vid.active = active_q;
  assign vid.hsync  = hsync_q;
  assign vid.vsync  = vsync_q;
  assign vid.fsync  = fsync_q;
  assign vid.lsync  = lsync_q;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts alongside fsync so the first frame already reads 1.
  always_comb begin
    frame_cnt_d = fsync_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Frame counter register; wraps naturally at 16 bits.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'h0000;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vid.frame_cnt = frame_cnt_q;
`else
  assign vid.frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench: full 720p timing plus a scaled raster for frames
module tb_video_timing_gen;

  typedef struct packed {
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               active;
    logic               hsync;
    logic               vsync;
    logic               fsync;
    logic               lsync;
    logic [15:0]        frame_cnt;
  } vid_t;

  typedef struct {
    int hres, hfp, hsw, hbp, vres, vfp, vsw, vbp;
    bit hpol, vpol;
  } tim_t;

  tim_t BT = '{hres:1280, hfp:110, hsw:40, hbp:220, vres:720, vfp:5, vsw:5, vbp:20, hpol:1'b1, vpol:1'b1};
  tim_t ST = '{hres:8, hfp:2, hsw:3, hbp:4, vres:4, vfp:1, vsw:2, vbp:3, hpol:1'b0, vpol:1'b1};

  localparam int B_RUN = 31 * 1650 + 100;

  logic pixel_clk = 1'b0;
  logic rst_b = 1'b1;
  logic rst_s = 1'b1;
  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen_if vb ();
  video_timing_gen_if vs ();

  video_timing_gen u_big (
    .pixel_clk (pixel_clk),
    .rst       (rst_b),
    .vid       (vb)
  );

  video_timing_gen #(
    .HRES(8), .HFP(2), .HSYNC(3), .HBP(4),
    .VRES(4), .VFP(1), .VSYNC(2), .VBP(3),
    .HS_POL(1'b0), .VS_POL(1'b1), .POS_W(12)
  ) u_small (
    .pixel_clk (pixel_clk),
    .rst       (rst_s),
    .vid       (vs)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic vid_t exp_vid(input tim_t t, input int h, input int v, input int fr);
    int hst = -(t.hfp + t.hsw + t.hbp);
    int vst = -(t.vfp + t.vsw + t.vbp);
    vid_t e;
    e.hpos      = 12'(h);
    e.vpos      = 12'(v);
    e.active    = (h >= 0) && (v >= 0);
    e.hsync     = (h >= hst + t.hfp && h < hst + t.hfp + t.hsw) ? t.hpol : !t.hpol;
    e.vsync     = (v >= vst + t.vfp && v < vst + t.vfp + t.vsw) ? t.vpol : !t.vpol;
    e.fsync     = (h == hst) && (v == vst);
    e.lsync     = (h == hst);
`ifdef VTG_FRAME_CNT_EN
    e.frame_cnt = 16'(fr);
`else
    e.frame_cnt = 16'h0000 & 16'(fr);
`endif
    return e;
  endfunction

  function automatic vid_t rst_vid(input tim_t t);
    vid_t e;
    e = '0;
    e.hpos  = 12'(t.hres - 1);
    e.vpos  = 12'(t.vres - 1);
    e.hsync = !t.hpol;
    e.vsync = !t.vpol;
    return e;
  endfunction

  task automatic step(input tim_t t, inout int h, inout int v, inout int fr);
    if (h == t.hres - 1) begin
      h = -(t.hfp + t.hsw + t.hbp);
      v = (v == t.vres - 1) ? -(t.vfp + t.vsw + t.vbp) : v + 1;
      if (v == -(t.vfp + t.vsw + t.vbp)) fr++;
    end else begin
      h++;
    end
  endtask

  vid_t b_obs, s_obs;
  assign b_obs = {vb.hpos, vb.vpos, vb.active, vb.hsync, vb.vsync, vb.fsync, vb.lsync, vb.frame_cnt};
  assign s_obs = {vs.hpos, vs.vpos, vs.active, vs.hsync, vs.vsync, vs.fsync, vs.lsync, vs.frame_cnt};

  vid_t b_q[$];
  vid_t s_q[$];
  int b_h, b_v, b_fr, s_h, s_v, s_fr;

  // Reference raster: advance on each edge out of reset and queue the expected outputs.
  always @(posedge pixel_clk) begin
    if (rst_b) begin
      b_h = BT.hres - 1; b_v = BT.vres - 1; b_fr = 0;
    end else begin
      step(BT, b_h, b_v, b_fr);
      b_q.push_back(exp_vid(BT, b_h, b_v, b_fr));
    end
    if (rst_s) begin
      s_h = ST.hres - 1; s_v = ST.vres - 1; s_fr = 0;
    end else begin
      step(ST, s_h, s_v, s_fr);
      s_q.push_back(exp_vid(ST, s_h, s_v, s_fr));
    end
  end

  // Scoreboard compare on the falling edge.
  always @(negedge pixel_clk) begin
    if (rst_b) check_val("b_rst", b_obs, rst_vid(BT));
    else if (b_q.size() > 0) check_val("b_pix", b_obs, b_q.pop_front());
    if (rst_s) check_val("s_rst", s_obs, rst_vid(ST));
    else if (s_q.size() > 0) check_val("s_pix", s_obs, s_q.pop_front());
  end

  int b_cyc = 0, b_last_ls = 0, b_hs_cnt = 0, b_vs_cnt = 0, b_act_cnt = 0, b_prev_h = 0;
  bit b_hs_prev = 0, b_act_prev = 0;

  // Line-level measurements on the full-size raster.
  always @(negedge pixel_clk) begin
    if (!rst_b) begin
      b_cyc++;
      if (vb.lsync) begin
        if (b_last_ls > 0) begin
          check_val("b_lsync_period", b_cyc - b_last_ls, 1650);
          check_val("b_hsync_len", b_hs_cnt, 40);
        end
        b_last_ls = b_cyc;
        b_hs_cnt  = 0;
      end
      if (vb.hsync) b_hs_cnt++;
      if (vb.hsync && !b_hs_prev) check_val("b_hsync_rise_h", vb.hpos, -260);
      if (vb.vsync) b_vs_cnt++;
      if (vb.active) b_act_cnt++;
      if (vb.active && !b_act_prev) begin
        check_val("b_act_rise_h", vb.hpos, 0);
        check_val("b_act_rise_v", vb.vpos, 0);
      end
      if (!vb.active && b_act_prev) check_val("b_act_fall_h", b_prev_h, 1279);
      b_hs_prev  = vb.hsync;
      b_act_prev = vb.active;
      b_prev_h   = int'(vb.hpos);
    end
  end

  int s_cyc = 0, s_last_fs = 0, s_act_cnt = 0, s_prev_h = 0, s_prev_v = 0;
  bit s_prev_act = 0;

  // Frame-level measurements on the scaled raster (17 x 10, 170 clocks/frame).
  always @(negedge pixel_clk) begin
    if (!rst_s) begin
      s_cyc++;
      if (vs.fsync) begin
        if (s_last_fs > 0) begin
          check_val("s_fsync_period", s_cyc - s_last_fs, 170);
          check_val("s_act_per_frame", s_act_cnt, 32);
          check_val("s_last_px_act", s_prev_act, 1);
          check_val("s_last_px_h", s_prev_h, 7);
          check_val("s_last_px_v", s_prev_v, 3);
        end
        s_last_fs = s_cyc;
        s_act_cnt = 0;
      end
      if (vs.active) s_act_cnt++;
      s_prev_act = vs.active;
      s_prev_h   = int'(vs.hpos);
      s_prev_v   = int'(vs.vpos);
    end else begin
      s_cyc = 0; s_last_fs = 0; s_act_cnt = 0; s_prev_act = 0;
    end
  end

  initial begin
    bit found;
    repeat (3) @(negedge pixel_clk);
    #2 rst_b = 1'b0; rst_s = 1'b0;

    @(negedge pixel_clk);
    check_val("b_first_h", vb.hpos, -370);
    check_val("b_first_v", vb.vpos, -30);
    check_val("b_first_fsync", vb.fsync, 1);
    check_val("b_first_lsync", vb.lsync, 1);
    check_val("b_first_active", vb.active, 0);
    check_val("s_first_h", vs.hpos, -9);
    check_val("s_first_v", vs.vpos, -6);

    repeat (400) @(negedge pixel_clk);
`ifdef VTG_FRAME_CNT_EN
    check_val("s_frame_cnt3", vs.frame_cnt, 3);
`else
    check_val("s_frame_cnt0", vs.frame_cnt, 0);
`endif

    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge pixel_clk);
      if (vs.hpos == 12'sd5 && vs.vpos == 12'sd2) found = 1;
    end
    check_val("s_reach_5_2", found, 1);

    #2 rst_s = 1'b1;
    #1;
    check_val("s_async_rst_h", vs.hpos, 7);
    check_val("s_async_rst_v", vs.vpos, 3);
    check_val("s_async_rst_hs", vs.hsync, 1);
    check_val("s_async_rst_act", vs.active, 0);
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    #2 rst_s = 1'b0;
    @(negedge pixel_clk);
    check_val("s_rel_h", vs.hpos, -9);
    check_val("s_rel_v", vs.vpos, -6);
    check_val("s_rel_fsync", vs.fsync, 1);
    check_val("s_rel_lsync", vs.lsync, 1);
    check_val("s_rel_fcnt", vs.frame_cnt,
`ifdef VTG_FRAME_CNT_EN
      1
`else
      0
`endif
    );
    repeat (400) @(negedge pixel_clk);

    for (int i = 0; i < 60000 && b_cyc < B_RUN; i++) @(negedge pixel_clk);
    check_val("b_run_done", b_cyc >= B_RUN, 1);
    check_val("b_vsync_clocks", b_vs_cnt, 8250);
    check_val("b_act_line0", b_act_cnt, 1280);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
